// File: rtl/conv_seq_pkg.sv
// Shared state encoding, array/feature-map geometry and address helpers for the conv sequencer.
package conv_seq_pkg;

    localparam int unsigned ARR      = 8;
    localparam int unsigned IN_W     = 6;
    localparam int unsigned KS       = 3;
    localparam int unsigned OUT_W    = IN_W - KS + 1;
    localparam int unsigned LOAD_GAP = 8;
    localparam int unsigned W_AW     = 7;
    localparam int unsigned A_AW     = 7;
    localparam int unsigned O_AW     = 9;
    localparam int unsigned CNT_W    = 4;

    localparam logic [CNT_W-1:0] J_LAST   = CNT_W'(ARR - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(LOAD_GAP - 1);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(OUT_W * OUT_W - 1);
    localparam logic [CNT_W-1:0] K_LAST   = CNT_W'(KS * KS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        WGAP,
        ACT,
        DRAIN_RD,
        DRAIN_WR,
        DONE
    } state_t;

    // Input pixel feeding output pixel pix under kernel tap k.
    function automatic int unsigned act_index(input int unsigned pix, input int unsigned k);
        return (pix / OUT_W + k / KS) * IN_W + (pix % OUT_W + k % KS);
    endfunction

endpackage

// File: rtl/conv_seq_ctrl_addr.sv
// Combinational weight/activation address generator from kernel position, weight row and pixel.
module conv_addr_gen
    import conv_seq_pkg::*;
(
    input  logic [CNT_W-1:0] k,
    input  logic [CNT_W-1:0] j,
    input  logic [CNT_W-1:0] pix,
    output logic [W_AW-1:0]  w_addr,
    output logic [A_AW-1:0]  act_addr
);

    assign w_addr   = W_AW'(32'(k) * ARR + 32'(j));
    assign act_addr = A_AW'(act_index(32'(pix), 32'(k)));

endmodule

// File: rtl/conv_seq_ctrl.sv
// Control sequencer for one 3x3 convolution on the 8x8 systolic core.
// Optional cycle counter on seq_cycles enabled by defining SEQ_PERF_CNT_EN.
module conv_seq_ctrl
    import conv_seq_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            seq_begin,
    output logic            seq_done,
    output logic            busy,
    output logic            w_cen,
    output logic            w_wen,
    output logic [W_AW-1:0] w_addr,
    output logic            act_cen,
    output logic            act_wen,
    output logic [A_AW-1:0] act_addr,
    output logic            op_cen,
    output logic            op_wen,
    output logic [O_AW-1:0] op_addr,
    output logic            arr_wload,
    output logic            arr_act_vld,
    input  logic            ofifo_valid,
    output logic            ofifo_rd,
    output logic            acc_first,
    output logic [15:0]     seq_cycles
);

    state_t           state, state_n;
    logic [CNT_W-1:0] k, k_n, cnt, cnt_n, pix, pix_n;
    logic [W_AW-1:0]  w_addr_g;
    logic [A_AW-1:0]  act_addr_g;

    conv_addr_gen u_addr (
        .k        (k),
        .j        (cnt),
        .pix      (pix),
        .w_addr   (w_addr_g),
        .act_addr (act_addr_g)
    );

    assign w_wen   = 1'b1;
    assign act_wen = 1'b1;

    always_comb begin
        state_n   = state;
        k_n       = k;
        cnt_n     = cnt;
        pix_n     = pix;
        seq_done  = 1'b0;
        busy      = (state != IDLE);
        w_cen     = 1'b1;
        w_addr    = '0;
        act_cen   = 1'b1;
        act_addr  = '0;
        op_cen    = 1'b1;
        op_wen    = 1'b1;
        op_addr   = '0;
        ofifo_rd  = 1'b0;
        acc_first = 1'b0;
        case (state)
            IDLE: begin
                if (seq_begin) begin
                    state_n = WLOAD;
                    k_n     = '0;
                    cnt_n   = '0;
                    pix_n   = '0;
                end
            end
            WLOAD: begin
                w_cen  = 1'b0;
                w_addr = w_addr_g;
                if (cnt == J_LAST) begin
                    cnt_n   = '0;
                    state_n = WGAP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WGAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    pix_n   = '0;
                    state_n = ACT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ACT: begin
                act_cen  = 1'b0;
                act_addr = act_addr_g;
                if (pix == PIX_LAST) begin
                    pix_n   = '0;
                    state_n = DRAIN_RD;
                end else begin
                    pix_n = pix + 1'b1;
                end
            end
            DRAIN_RD: begin
                acc_first = (k == '0);
                op_addr   = O_AW'(pix);
                if (ofifo_valid) begin
                    ofifo_rd = 1'b1;
                    op_cen   = 1'b0;
                    state_n  = DRAIN_WR;
                end
            end
            DRAIN_WR: begin
                acc_first = (k == '0);
                op_addr   = O_AW'(pix);
                op_cen    = 1'b0;
                op_wen    = 1'b0;
                if (pix != PIX_LAST) begin
                    pix_n   = pix + 1'b1;
                    state_n = DRAIN_RD;
                end else if (k != K_LAST) begin
                    k_n     = k + 1'b1;
                    pix_n   = '0;
                    cnt_n   = '0;
                    state_n = WLOAD;
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                seq_done = 1'b1;
                k_n      = '0;
                cnt_n    = '0;
                pix_n    = '0;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Array valids trail the SRAM enables by the one-cycle read latency.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            k           <= '0;
            cnt         <= '0;
            pix         <= '0;
            arr_wload   <= 1'b0;
            arr_act_vld <= 1'b0;
        end else begin
            state       <= state_n;
            k           <= k_n;
            cnt         <= cnt_n;
            pix         <= pix_n;
            arr_wload   <= ~w_cen;
            arr_act_vld <= ~act_cen;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] perf;

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf <= '0;
        end else if (state == IDLE && seq_begin) begin
            perf <= '0;
        end else if (state != IDLE && perf != '1) begin
            perf <= perf + 16'd1;
        end
    end

    assign seq_cycles = perf;
`else
    assign seq_cycles = '0;
`endif

endmodule
